// File: rtl/rate_tx_sender_if.sv
// Frame-buffer read port, rate requests and modulator output of the rate TX sender.
// The master side is the environment, the slave side is the sender.
interface rate_tx_sender_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              send40k_en;
    logic              send10k_en;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [31:0]       start_delay;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              data_send_end;
    logic [63:0]       debug;

    modport master (
        output send40k_en, send10k_en, wr_addr_out, start_delay, rd_data,
        input  rd_en, rd_addr, tx_data, tx_valid, data_send_end, debug
    );

    modport slave (
        input  send40k_en, send10k_en, wr_addr_out, start_delay, rd_data,
        output rd_en, rd_addr, tx_data, tx_valid, data_send_end, debug
    );
endinterface

// File: rtl/rate_tx_sender.sv
// Reads a frame of N words from the buffer and emits one word per symbol tick
// at 40 kHz or 10 kHz, after an optional start offset; pulses data_send_end on completion.
module rate_tx_sender #(
    parameter int DIV_40K = 1250,
    parameter int DIV_10K = 5000,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
) (
    input  logic                clk_50m,
    input  logic                cfg_rst,
    rate_tx_sender_if.slave     bus
);
    localparam int TICK_W = $clog2(DIV_10K);

    typedef enum logic [1:0] {IDLE, ALIGN, SEND, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_en40_q;
    logic              r_en10_q;
    logic              r_rate;
    logic [TICK_W-1:0] r_div;
    logic [ADDR_W-1:0] r_len;
    logic [31:0]       r_dly;
    logic [ADDR_W-1:0] r_sym;
    logic [TICK_W-1:0] r_tick;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_end;

    logic w_rise40;
    logic w_rise10;
    logic w_trig;
    logic w_any_en;
    logic w_rd_en;
    logic w_last;

    always_ff @(posedge clk_50m or posedge cfg_rst) begin
        if (cfg_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_rise40 = bus.send40k_en & ~r_en40_q;
        w_rise10 = bus.send10k_en & ~r_en10_q;
        w_trig   = w_rise40 | w_rise10;
        w_any_en = bus.send40k_en | bus.send10k_en;
        w_rd_en  = (r_state == SEND) && (r_tick == '0);
        w_last   = w_rd_en && (r_sym == r_len - ADDR_W'(1));
        w_next   = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_trig) begin
                    if (bus.wr_addr_out == '0) begin
                        w_next = DONE;
                    end else if (bus.start_delay == '0) begin
                        w_next = SEND;
                    end else begin
                        w_next = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (!w_any_en) begin
                    w_next = IDLE;
                end else if (r_dly == 32'd1) begin
                    w_next = SEND;
                end
            end
            // Abort takes priority over completion: dropping both enables never yields an end pulse.
            SEND: begin
                if (!w_any_en) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or posedge cfg_rst) begin
        if (cfg_rst) begin
            r_en40_q   <= 1'b0;
            r_en10_q   <= 1'b0;
            r_rate     <= 1'b0;
            r_div      <= '0;
            r_len      <= '0;
            r_dly      <= '0;
            r_sym      <= '0;
            r_tick     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            r_en40_q   <= bus.send40k_en;
            r_en10_q   <= bus.send10k_en;
            r_tx_valid <= w_rd_en;
            r_end      <= (r_state == DONE);
            if (w_rd_en) begin
                r_tx_data <= bus.rd_data;
            end
            unique case (r_state)
                IDLE: begin
                    r_sym  <= '0;
                    r_tick <= '0;
                    if (w_trig) begin
                        r_rate <= w_rise40;
                        r_div  <= w_rise40 ? TICK_W'(DIV_40K - 1) : TICK_W'(DIV_10K - 1);
                        r_len  <= bus.wr_addr_out;
                        r_dly  <= bus.start_delay;
                    end
                end
                ALIGN: begin
                    r_dly  <= r_dly - 32'd1;
                    r_tick <= '0;
                end
                SEND: begin
                    if (w_rd_en) begin
                        r_sym <= r_sym + ADDR_W'(1);
                    end
                    r_tick <= (r_tick == r_div) ? '0 : r_tick + TICK_W'(1);
                end
                DONE: begin
                    r_sym  <= '0;
                    r_tick <= '0;
                end
                default: begin
                    r_sym  <= '0;
                    r_tick <= '0;
                end
            endcase
        end
    end

    assign bus.rd_en         = w_rd_en;
    assign bus.rd_addr       = (r_state == SEND) ? r_sym : '0;
    assign bus.tx_data       = r_tx_data;
    assign bus.tx_valid      = r_tx_valid;
    assign bus.data_send_end = r_end;
    assign bus.debug         = 64'({r_state, r_rate, r_sym, r_tick,
                                    r_en40_q, r_en10_q, r_tx_valid, r_end});
endmodule
